// File: rtl/xor_stage_pkg.sv
// Shared types and constants for consumers of transition-encoded XOR cell outputs.
package xor_stage_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  localparam int unsigned DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/transition_decoder.sv
// Turns a transition-encoded level into data bits: a level change decodes as 1.
module transition_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic bit_out
);

  logic din_q;

  // Previous-level register; loads din during reset so nothing spurious decodes afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= din;
    end else begin
      din_q <= din;
    end
  end

  assign bit_out = din ^ din_q;

endmodule

// File: rtl/xor_out_deserializer.sv
// Packs decoded transition bits LSB-first into words with a drop-on-full valid/ready handoff.
// Optional XOR_DESER_PARITY_EN adds a registered even-parity output aligned with word_data.
module xor_out_deserializer
  import xor_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  din,
  output logic [WIDTH-1:0]      word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef XOR_DESER_PARITY_EN
  ,
  output logic                  word_parity
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deser_state_t     state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic             complete;
  logic             dec_bit;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  transition_decoder u_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .bit_out(dec_bit)
  );

  // Next-state, bit placement and word-completion detection.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt   = SHIFT;
          shift_nxt   = {{(WIDTH-1){1'b0}}, dec_bit};
          bit_cnt_nxt = CNT_W'(1);
        end else begin
          bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (en) begin
          shift_nxt[bit_cnt] = dec_bit;
          if (bit_cnt == LAST_BIT) begin
            complete    = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end else begin
          // Partial word is abandoned, never emitted.
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          shift_nxt   = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
        shift_nxt   = '0;
      end
    endcase
  end

  // Assembly state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Output word handoff; a completed word is dropped when the slot is still occupied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else if (complete) begin
      if (!word_valid || word_ready) begin
        word_data  <= shift_nxt;
        word_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
        if (drop_cnt != DROP_CNT_MAX) begin
          drop_cnt <= drop_cnt + 8'd1;
        end else begin
          drop_cnt <= drop_cnt;
        end
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_valid;
    end
  end

`ifdef XOR_DESER_PARITY_EN
  // Parity loads on exactly the same condition as word_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_parity <= 1'b0;
    end else if (complete && (!word_valid || word_ready)) begin
      word_parity <= even_parity(shift_nxt);
    end else begin
      word_parity <= word_parity;
    end
  end
`endif

endmodule
